// File: rtl/reg_dump_ctrl_pkg.sv
// Shared widths and FSM encoding for the register-dump controller.
package reg_dump_ctrl_pkg;
  localparam int BITSIZE = 64;
  localparam int REGSIZE = 32;
  localparam int SELW    = $clog2(REGSIZE);
  localparam int CNTW    = SELW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND0 = 3'd2,
    SEND1 = 3'd3,
    FIN   = 3'd4
  } dumpState_t;
endpackage

// File: rtl/reg_dump_ctrl.sv
// Streams a wrapping range of register-file entries, reading two per fetch.
// Latency: first beat two cycles after start; beats stall while m_ready is low.
module reg_dump_ctrl #(
  parameter int BITSIZE = reg_dump_ctrl_pkg::BITSIZE,
  parameter int REGSIZE = reg_dump_ctrl_pkg::REGSIZE,
  localparam int SelW = $clog2(REGSIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SelW-1:0]    first_reg,
  input  logic [SelW-1:0]    last_reg,
  input  logic               abort,
  output logic [SelW-1:0]    ReadSelect1,
  output logic [SelW-1:0]    ReadSelect2,
  input  logic [BITSIZE-1:0] ReadData1,
  input  logic [BITSIZE-1:0] ReadData2,
  output logic [BITSIZE-1:0] m_data,
  output logic [SelW-1:0]    m_index,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               done
);
  import reg_dump_ctrl_pkg::*;

  localparam int CntW = SelW + 1;

  dumpState_t state, stateNext;

  logic [SelW-1:0]    ptr;
  logic [CntW-1:0]    cnt;
  logic [BITSIZE-1:0] bufA, bufB;
  logic [SelW-1:0]    idxA, idxB;
  logic               bUsed;

  logic               takeStart, enterFetch, beat;
  logic [CntW-1:0]    cntDec, cntLoad;
  logic [SelW-1:0]    span, fetchPtr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    takeStart  = 1'b0;
    enterFetch = 1'b0;
    beat       = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    cntDec     = cnt - CntW'(1);
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          takeStart  = 1'b1;
          enterFetch = 1'b1;
          stateNext  = FETCH;
        end
      end
      FETCH: stateNext = SEND0;
      SEND0: begin
        m_valid = 1'b1;
        if (m_ready) begin
          beat = 1'b1;
          if (bUsed)               stateNext = SEND1;
          else if (cntDec != '0) begin stateNext = FETCH; enterFetch = 1'b1; end
          else                     stateNext = FIN;
        end
      end
      SEND1: begin
        m_valid = 1'b1;
        if (m_ready) begin
          beat = 1'b1;
          if (cntDec != '0) begin stateNext = FETCH; enterFetch = 1'b1; end
          else                stateNext = FIN;
        end
      end
      FIN: begin
        done      = !abort;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Cancel wins over any handshake landing in the same cycle.
    if (abort && state != IDLE) begin
      stateNext  = IDLE;
      beat       = 1'b0;
      enterFetch = 1'b0;
    end
  end

  assign span     = last_reg - first_reg;
  assign cntLoad  = {1'b0, span} + CntW'(1);
  assign fetchPtr = takeStart ? first_reg : ptr;

  assign m_data  = (state == SEND1) ? bufB : bufA;
  assign m_index = (state == SEND1) ? idxB : idxA;

  // Selects are registered on the way into FETCH so they hold between fetches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      cnt         <= '0;
      bufA        <= '0;
      bufB        <= '0;
      idxA        <= '0;
      idxB        <= '0;
      bUsed       <= 1'b0;
      ReadSelect1 <= '0;
      ReadSelect2 <= '0;
    end else begin
      if (takeStart) begin
        ptr <= first_reg;
        cnt <= cntLoad;
      end
      if (enterFetch) begin
        ReadSelect1 <= fetchPtr;
        ReadSelect2 <= fetchPtr + SelW'(1);
      end
      if (state == FETCH) begin
        bufA  <= ReadData1;
        bufB  <= ReadData2;
        idxA  <= ReadSelect1;
        idxB  <= ReadSelect2;
        bUsed <= (cnt != CntW'(1));
        ptr   <= ptr + SelW'(2);
      end
      if (beat) cnt <= cntDec;
    end
  end
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl against a 32x64 register file holding 100+10*i.
module tb_reg_dump_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        m_ready = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  ReadSelect1, ReadSelect2, m_index;
  logic [63:0] ReadData1, ReadData2, m_data;
  logic        m_valid, busy, done;

  logic [63:0] rf [32];
  int errors = 0;
  int checks = 0;

  logic [4:0]  gotIdx [$];
  logic [63:0] gotDat [$];
  int          doneSeen = 0;
  logic        holdPrev = 1'b0;
  logic [4:0]  holdIdx = '0;
  logic [63:0] holdDat = '0;

  always #5 clk = ~clk;

  assign ReadData1 = rf[ReadSelect1];
  assign ReadData2 = rf[ReadSelect2];

  reg_dump_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .abort(abort), .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .m_data(m_data), .m_index(m_index),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
  );

  function automatic logic [63:0] regVal(input int i);
    return 64'(100 + 10 * i);
  endfunction

  function automatic int countOf(input int f, input int l);
    return ((l - f + 32) % 32) + 1;
  endfunction

  function automatic int cyclesFor(input int n);
    return 3 * ((n + 1) / 2) - (n % 2);
  endfunction

  function automatic logic pickReady(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((n + 1) % 2) == 1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfer log and hold-stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (holdPrev) begin
        check("hold_valid", m_valid, 1);
        check("hold_index", m_index, holdIdx);
        check("hold_data", m_data, holdDat);
      end
      if (m_valid && m_ready && !abort) begin
        gotIdx.push_back(m_index);
        gotDat.push_back(m_data);
      end
      if (done) doneSeen++;
      holdPrev <= m_valid && !m_ready && !abort;
      holdIdx  <= m_index;
      holdDat  <= m_data;
    end else begin
      holdPrev <= 1'b0;
    end
  end

  task automatic runDump(input int f, input int l, input int mode, input bit poke);
    int n, expN, doneAt, lim;
    bit busyOk;
    gotIdx.delete();
    gotDat.delete();
    doneSeen  = 0;
    expN      = countOf(f, l);
    first_reg = 5'(f);
    last_reg  = 5'(l);
    start     = 1'b1;
    m_ready   = pickReady(mode, 0);
    tick();
    start = 1'b0;
    check("fetch_valid", m_valid, 0);
    check("fetch_busy", busy, 1);
    m_ready = pickReady(mode, 1);
    doneAt = 0;
    busyOk = 1'b1;
    n = 0;
    while (doneAt == 0 && n < 2000) begin
      tick();
      n++;
      if (n == 1) check("first_valid", m_valid, 1);
      if (!busy) busyOk = 1'b0;
      if (done) doneAt = n;
      start = poke && (n == 1);
      if (poke) begin
        first_reg = 5'd20;
        last_reg  = 5'd25;
      end
      m_ready = pickReady(mode, n + 1);
    end
    start = 1'b0;
    check("done_seen", doneAt != 0, 1);
    if (mode == 0) check("dump_cycles", doneAt, cyclesFor(expN));
    check("busy_thru", busyOk, 1);
    tick();
    check("idle_busy", busy, 0);
    check("done_once", done, 0);
    if (poke) begin
      repeat (4) tick();
      check("restart_ignored", busy, 0);
    end
    check("done_count", doneSeen, 1);
    check("beat_count", gotIdx.size(), expN);
    lim = (gotIdx.size() < expN) ? gotIdx.size() : expN;
    for (int k = 0; k < lim; k++) begin
      check("beat_index", gotIdx[k], (f + k) % 32);
      check("beat_data", gotDat[k], regVal((f + k) % 32));
    end
    m_ready = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf[i] = regVal(i);

    #2;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", m_data, 0);
    check("rst_index", m_index, 0);
    check("rst_sel1", ReadSelect1, 0);
    check("rst_sel2", ReadSelect2, 0);
    #10 rst = 1'b1;
    tick();

    runDump(0, 31, 0, 1'b0);   // full dump
    runDump(30, 2, 0, 1'b0);   // odd wrap range
    runDump(4, 5, 1, 1'b0);    // toggling backpressure
    runDump(7, 7, 0, 1'b1);    // single register, start while busy

    repeat (6) runDump($urandom_range(0, 31), $urandom_range(0, 31), 2, 1'b0);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", busy, 0);

    // abort after the third beat of a full dump
    gotIdx.delete();
    gotDat.delete();
    doneSeen  = 0;
    first_reg = 5'd0;
    last_reg  = 5'd31;
    m_ready   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (gotIdx.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check("abort_reach", gotIdx.size(), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", m_valid, 0);
    check("abort_done", done, 0);
    repeat (3) tick();
    check("abort_no_done", doneSeen, 0);
    check("abort_beats", gotIdx.size(), 3);
    for (int k = 0; k < 3 && k < gotIdx.size(); k++)
      check("abort_index", gotIdx[k], k);

    // reset in the middle of a dump
    first_reg = 5'd0;
    last_reg  = 5'd31;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_index", m_index, 0);
    check("mid_rst_sel1", ReadSelect1, 0);
    check("mid_rst_sel2", ReadSelect2, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    runDump(10, 13, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 SHALL have parameter BITSIZE, default 64, meaning the register data width.
REQ-002 SHALL have parameter REGSIZE, default 32, meaning the register count; the select width is $clog2(REGSIZE), which is 5 at the default.
REQ-003 SHALL have a single clock and asynchronous active-low reset, in this port order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset; 0 resets the block.
REQ-004 SHALL have the remaining ports:
- start  in  1  begin a dump of the range first_reg..last_reg.
- first_reg  in  5  first register index, sampled at start.
- last_reg  in  5  last register index, sampled at start.
- abort  in  1  synchronous cancel of a dump in progress.
- ReadSelect1  out  5  register file read port 1 select.
- ReadSelect2  out  5  register file read port 2 select.
- ReadData1  in  64  register file port 1 data; combinational from ReadSelect1.
- ReadData2  in  64  register file port 2 data; combinational from ReadSelect2.
- m_data  out  64  dumped register value.
- m_index  out  5  index of the register in m_data.
- m_valid  out  1  m_data and m_index are valid.
- m_ready  in  1  sink accepts the beat.
- busy  out  1  a dump is in progress.
- done  out  1  one-cycle pulse when a dump completes.

Function
REQ-005 SHALL implement the FSM states IDLE, FETCH, SEND0, SEND1 and FIN.
REQ-006 In IDLE, start=1 SHALL latch first_reg and last_reg, load the pointer to first_reg, load remaining count = ((last_reg - first_reg) mod 32) + 1, and go to FETCH.
- The count is 6 bits with range 1..32.
REQ-007 Range wrap-around: if first_reg > last_reg, the dump SHALL run through index 31 and continue from index 0.
- first_reg == last_reg SHALL dump exactly one register.
REQ-008 In FETCH, the block SHALL drive ReadSelect1 = ptr and ReadSelect2 = (ptr+1) mod 32, and capture both ReadData values into a two-entry buffer at the clock edge ending the cycle.
REQ-009 In FETCH with remaining count == 1, only entry A SHALL be marked used.
REQ-010 Outside FETCH, ReadSelect1 and ReadSelect2 SHALL hold their last values; both SHALL be 0 after reset.
REQ-011 SEND0 SHALL present entry A on m_data/m_index with m_valid=1.
- It SHALL hold until m_ready=1.
- On acceptance it SHALL go to SEND1 if entry B is used, else to FETCH if count remains, else to FIN.
REQ-012 SEND1 SHALL present entry B under the same rules and, on acceptance, go to FETCH or FIN.
REQ-013 A beat SHALL transfer only on a cycle where m_valid and m_ready are both 1; m_data and m_index SHALL stay stable while m_valid=1 and m_ready=0.
REQ-014 The pointer SHALL advance by 2 (mod 32) per pair and the count SHALL decrement per accepted beat; the pointer and count SHALL never underflow.
REQ-015 Latency: with start high at edge k, the first m_valid SHALL be high in cycle k+2. With m_ready held at 1, N registers SHALL take 3*ceil(N/2)-(N mod 2) cycles from FETCH entry to FIN.
REQ-016 FIN SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 start while busy SHALL be ignored; no queuing.
REQ-019 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with m_valid=0 and no done pulse.
- abort takes precedence over a simultaneous handshake.
- abort and start together in IDLE: start SHALL be ignored.
REQ-020 The block SHALL not modify register contents; index 31 SHALL be dumped with whatever value the register file returns for it.

Reset
REQ-021 rst=0 SHALL immediately force state=IDLE and set m_valid, busy, done, m_data, m_index, ReadSelect1, ReadSelect2, the pointer, the count and both buffer entries to 0.
REQ-022 Reset during a dump SHALL discard the dump, with no done pulse; the first clk edge after rst returns to 1 SHALL be treated as IDLE.

Structure
REQ-023 A shared package SHALL hold BITSIZE, REGSIZE, the select width and the FSM state encoding.
REQ-024 The block SHALL be one module with no sub-module; the two-entry buffer is inline registers.

Verification
REQ-025 The bench SHALL pair the block with a 32x64 register file preloaded with reg i = 100+10*i and cover:
- Full dump: first=0, last=31, m_ready=1 -> 32 beats with index 0..31 and data 100..410, then done one cycle later; busy high throughout.
- Odd wrap range: first=30, last=2 -> 5 beats with indices 30,31,0,1,2 and data 400,410,100,110,120; the final FETCH uses only port 1.
- Backpressure: first=4, last=5, m_ready toggling 0/1 each cycle -> beats (4,140) and (5,150), each held stable while m_ready=0; exactly 2 transfers.
- Single register: first=last=7 -> one beat (7,170), done pulse, return to IDLE; a second start during busy is ignored.
- Abort and reset: abort after the 3rd beat of a 0..31 dump -> IDLE next cycle, no done. Separately, rst=0 mid-dump -> all outputs 0 immediately, and a fresh dump afterwards runs correctly.
